// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath: sequences fetch (T0..T2) and the
// ALU/MUL/DIV execute steps (T3..T6), deriving strobes from state and IR.
module control_sequencer #(
    parameter int REG_SEL_W  = 4,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Clear,
    input  logic                 Run,
    input  logic [31:0]          IR,
    output logic                 PCout,
    output logic                 Zhiout,
    output logic                 Zlowout,
    output logic                 MDRout,
    output logic                 HIout,
    output logic                 LOout,
    output logic                 MARin,
    output logic                 Zin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 IncPC,
    output logic                 Read,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 AND,
    output logic                 OR,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 Rout_en,
    output logic [REG_SEL_W-1:0] Rout_sel,
    output logic                 Rin_en,
    output logic [REG_SEL_W-1:0] Rin_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILLEGAL
    } state_t;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_add, op_sub, op_and, op_div, op_mul, op_or;
    logic       legal, is_muldiv;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign op_add    = (opcode == 5'b00000);
    assign op_sub    = (opcode == 5'b00001);
    assign op_and    = (opcode == 5'b00010);
    assign op_div    = (opcode == 5'b00011);
    assign op_mul    = (opcode == 5'b00100);
    assign op_or     = (opcode == 5'b00101);
    assign legal     = op_add | op_sub | op_and | op_div | op_mul | op_or;
    assign is_muldiv = op_mul | op_div;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        Zhiout   = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        ADD      = 1'b0;
        SUB      = 1'b0;
        AND      = 1'b0;
        OR       = 1'b0;
        MUL      = 1'b0;
        DIV      = 1'b0;
        Rout_en  = 1'b0;
        Rout_sel = '0;
        Rin_en   = 1'b0;
        Rin_sel  = '0;
        busy     = 1'b1;
        done     = 1'b0;
        illegal  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (Run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            // IR is still loading here, so decoding waits until T3.
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    Rout_en  = 1'b1;
                    Rout_sel = REG_SEL_W'(rb);
                    Yin      = 1'b1;
                    state_d  = S_T4;
                end else begin
                    state_d  = S_ILLEGAL;
                end
            end
            S_T4: begin
                Rout_en  = 1'b1;
                Rout_sel = REG_SEL_W'(rc);
                Zin      = 1'b1;
                ADD      = op_add;
                SUB      = op_sub;
                AND      = op_and;
                OR       = op_or;
                MUL      = op_mul;
                DIV      = op_div;
                state_d  = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin_en  = 1'b1;
                    Rin_sel = REG_SEL_W'(ra);
                    done    = 1'b1;
                    state_d = (CONTINUOUS && Run) ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                Zhiout  = 1'b1;
                HIin    = 1'b1;
                done    = 1'b1;
                state_d = (CONTINUOUS && Run) ? S_T0 : S_IDLE;
            end
            S_ILLEGAL: begin
                busy    = 1'b0;
                illegal = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-state strobe vectors for DIV, ADD,
// back-to-back, illegal opcode and Clear mid-instruction, plus bus exclusivity.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear, Run;
    logic [31:0] IR;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read;
    logic ADD, SUB, AND, OR, MUL, DIV;
    logic Rout_en, Rin_en, busy, done, illegal;
    logic [3:0] Rout_sel, Rin_sel;

    int total = 0;
    int bad   = 0;
    int excl_bad = 0;

    control_sequencer #(.REG_SEL_W(4), .CONTINUOUS(1'b1)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .MUL(MUL), .DIV(DIV), .Rout_en(Rout_en), .Rout_sel(Rout_sel),
        .Rin_en(Rin_en), .Rin_sel(Rin_sel), .busy(busy), .done(done),
        .illegal(illegal)
    );

    always #5 Clock = ~Clock;

    logic [34:0] obs;
    assign obs = {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, MARin, Zin, PCin,
                  MDRin, IRin, Yin, HIin, LOin, IncPC, Read, ADD, SUB, AND, OR,
                  MUL, DIV, Rout_en, Rout_sel, Rin_en, Rin_sel, busy, done, illegal};

    localparam logic [34:0] M_PCOUT   = 35'd1 << 34;
    localparam logic [34:0] M_ZHIOUT  = 35'd1 << 33;
    localparam logic [34:0] M_ZLOWOUT = 35'd1 << 32;
    localparam logic [34:0] M_MDROUT  = 35'd1 << 31;
    localparam logic [34:0] M_MARIN   = 35'd1 << 28;
    localparam logic [34:0] M_ZIN     = 35'd1 << 27;
    localparam logic [34:0] M_PCIN    = 35'd1 << 26;
    localparam logic [34:0] M_MDRIN   = 35'd1 << 25;
    localparam logic [34:0] M_IRIN    = 35'd1 << 24;
    localparam logic [34:0] M_YIN     = 35'd1 << 23;
    localparam logic [34:0] M_HIIN    = 35'd1 << 22;
    localparam logic [34:0] M_LOIN    = 35'd1 << 21;
    localparam logic [34:0] M_INCPC   = 35'd1 << 20;
    localparam logic [34:0] M_READ    = 35'd1 << 19;
    localparam logic [34:0] M_ADD     = 35'd1 << 18;
    localparam logic [34:0] M_MUL     = 35'd1 << 14;
    localparam logic [34:0] M_DIV     = 35'd1 << 13;
    localparam logic [34:0] M_ROUTEN  = 35'd1 << 12;
    localparam logic [34:0] M_RINEN   = 35'd1 << 7;
    localparam logic [34:0] M_BUSY    = 35'd1 << 2;
    localparam logic [34:0] M_DONE    = 35'd1 << 1;
    localparam logic [34:0] M_ILLEGAL = 35'd1;

    localparam logic [34:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_BUSY;
    localparam logic [34:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_BUSY;
    localparam logic [34:0] F2 = M_MDROUT | M_IRIN | M_BUSY;

    localparam logic [31:0] IR_DIV = 32'h1A92_0000;  // Rb=2 Rc=4
    localparam logic [31:0] IR_ADD = 32'h0291_8000;  // Ra=5 Rb=2 Rc=3
    localparam logic [31:0] IR_MUL = 32'h2091_8000;  // Rb=2 Rc=3
    localparam logic [31:0] IR_BAD = 32'hF800_0000;

    function automatic logic [34:0] rsel(input int v);
        return 35'(v) << 8;
    endfunction

    function automatic logic [34:0] wsel(input int v);
        return 35'(v) << 3;
    endfunction

    logic [34:0] div_seq [7];
    logic [34:0] add_seq [6];

    initial begin
        div_seq[0] = F0;
        div_seq[1] = F1;
        div_seq[2] = F2;
        div_seq[3] = M_ROUTEN | rsel(2) | M_YIN | M_BUSY;
        div_seq[4] = M_ROUTEN | rsel(4) | M_DIV | M_ZIN | M_BUSY;
        div_seq[5] = M_ZLOWOUT | M_LOIN | M_BUSY;
        div_seq[6] = M_ZHIOUT | M_HIIN | M_BUSY | M_DONE;
        add_seq[0] = F0;
        add_seq[1] = F1;
        add_seq[2] = F2;
        add_seq[3] = M_ROUTEN | rsel(2) | M_YIN | M_BUSY;
        add_seq[4] = M_ROUTEN | rsel(3) | M_ADD | M_ZIN | M_BUSY;
        add_seq[5] = M_ZLOWOUT | M_RINEN | wsel(5) | M_BUSY | M_DONE;
    end

    // Bus-driver and ALU-op exclusivity watched on every cycle.
    always @(negedge Clock) begin
        if (32'(PCout) + 32'(Zhiout) + 32'(Zlowout) + 32'(MDRout) + 32'(HIout)
            + 32'(LOout) + 32'(Rout_en) > 1)
            excl_bad++;
        if (32'(ADD) + 32'(SUB) + 32'(AND) + 32'(OR) + 32'(MUL) + 32'(DIV) > 1)
            excl_bad++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Clear = 1'b1; Run = 1'b1; IR = IR_DIV;
        tick();
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL reset obs=%h exp=%h", obs, 35'd0);
        end
        Clear = 1'b0; Run = 1'b0;
        tick();
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL idle_hold obs=%h exp=%h", obs, 35'd0);
        end
        $display("test_reset: done");
    endtask

    task automatic test_div();
        int busy_cnt = 0;
        IR = IR_DIV; Run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (busy) busy_cnt++;
            total++;
            if (obs !== div_seq[i]) begin
                bad++;
                $display("FAIL div_t%0d obs=%h exp=%h", i, obs, div_seq[i]);
            end
        end
        Run = 1'b0;
        tick();
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL div_to_idle obs=%h exp=%h", obs, 35'd0);
        end
        total++;
        if (busy_cnt !== 7) begin
            bad++;
            $display("FAIL div_busy_cycles got=%0d exp=7", busy_cnt);
        end
        $display("test_div: done");
    endtask

    task automatic test_add();
        int hilo = 0;
        IR = IR_ADD; Run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) Run = 1'b0;  // dropping Run mid-instruction must not abort it
            if (HIin || LOin) hilo++;
            total++;
            if (obs !== add_seq[i]) begin
                bad++;
                $display("FAIL add_t%0d obs=%h exp=%h", i, obs, add_seq[i]);
            end
        end
        tick();
        total++;
        if (obs !== 35'd0 || hilo !== 0) begin
            bad++;
            $display("FAIL add_end obs=%h exp=%h hilo=%0d", obs, 35'd0, hilo);
        end
        $display("test_add: done");
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        int done_cnt = 0;
        IR = IR_DIV; Run = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (i == 6) IR = IR_ADD;
            if (i == 12) Run = 1'b0;
            if (i == 7) begin
                total++;
                if (obs !== F0) begin
                    bad++;
                    $display("FAIL b2b_second_t0 obs=%h exp=%h", obs, F0);
                end
            end
            if (i == 12) begin
                total++;
                if (obs !== add_seq[5]) begin
                    bad++;
                    $display("FAIL b2b_add_t5 obs=%h exp=%h", obs, add_seq[5]);
                end
            end
        end
        tick();
        total++;
        if (busy_cnt !== 13 || done_cnt !== 2 || obs !== 35'd0) begin
            bad++;
            $display("FAIL b2b_counts busy=%0d done=%0d obs=%h exp busy=13 done=2 obs=0",
                     busy_cnt, done_cnt, obs);
        end
        $display("test_back_to_back: done");
    endtask

    task automatic test_illegal();
        int held = 0;
        IR = IR_BAD; Run = 1'b1;
        repeat (4) tick();
        total++;
        if (obs !== M_BUSY) begin
            bad++;
            $display("FAIL illegal_t3 obs=%h exp=%h", obs, M_BUSY);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs === M_ILLEGAL) held++;
        end
        total++;
        if (held !== 20) begin
            bad++;
            $display("FAIL illegal_hold got=%0d exp=20", held);
        end
        Clear = 1'b1;
        tick();
        Clear = 1'b0; Run = 1'b0;
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL illegal_clear obs=%h exp=%h", obs, 35'd0);
        end
        $display("test_illegal: done");
    endtask

    task automatic test_clear_mid();
        int hilo = 0;
        IR = IR_MUL; Run = 1'b1;
        repeat (5) tick();
        total++;
        if (obs !== (M_ROUTEN | rsel(3) | M_MUL | M_ZIN | M_BUSY)) begin
            bad++;
            $display("FAIL mul_t4 obs=%h exp=%h", obs,
                     M_ROUTEN | rsel(3) | M_MUL | M_ZIN | M_BUSY);
        end
        Clear = 1'b1;
        tick();
        Clear = 1'b0; Run = 1'b0;
        total++;
        if (obs !== 35'd0) begin
            bad++;
            $display("FAIL clear_mid obs=%h exp=%h", obs, 35'd0);
        end
        repeat (4) begin
            tick();
            if (HIin || LOin || busy) hilo++;
        end
        total++;
        if (hilo !== 0) begin
            bad++;
            $display("FAIL clear_mid_after got=%0d exp=0", hilo);
        end
        $display("test_clear_mid: done");
    endtask

    task automatic test_exclusion();
        total++;
        if (excl_bad !== 0) begin
            bad++;
            $display("FAIL exclusion violations=%0d exp=0", excl_bad);
        end
        $display("test_exclusion: done");
    endtask

    initial begin
        Clear = 1'b1; Run = 1'b0; IR = 32'd0;
        test_reset();
        test_div();
        test_add();
        test_back_to_back();
        test_illegal();
        test_clear_mid();
        test_exclusion();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule
